// File: rtl/pipe_ctrl_mdu.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_mdu
//   Five-stage MIPS pipeline controller with a multi-cycle multiply/divide
//   unit (MDU) interlock. Decodes opcode/funct combinationally in D, then
//   carries the control word through the E, M and W pipeline registers.
//   A busy counter tracks the MDU after each start. While it runs, F/D are
//   frozen if D holds an instruction that needs the MDU (mfhi, mflo, mult,
//   div).
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   opD, functD    D-stage opcode / funct
//   equalD         register compare result from D
//   flushE         hazard-unit request to bubble E
//   pcsrcD         branch taken
//   branchD, branchNOTD, jumpD, jumpR   beq / bne / j,jal / jr decoded in D
//   alusrcE, regdstE, alucontrolE       E-stage datapath controls
//   regwriteE/M/W, memtoregE/M/W        per-stage write-back controls
//   memwriteM, loadbyteM, savebyteM     M-stage memory controls
//   mdu_startE, mdu_opE, mdu_busy       MDU start pulse, op (0 mult, 1 div), busy
//   stallF, stallD                      freeze PC and IF/ID
//   moveW, hiloselW                     write-back from HI/LO, 1 = HI
// ---------------------------------------------------------------------------
module pipe_ctrl_mdu #(
    parameter int OPW     = 6,
    parameter int FNW     = 6,
    parameter int ACW     = 4,
    parameter int MDU_LAT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opD,
    input  logic [FNW-1:0] functD,
    input  logic           equalD,
    input  logic           flushE,
    output logic           pcsrcD,
    output logic           branchD,
    output logic           branchNOTD,
    output logic           jumpD,
    output logic           jumpR,
    output logic           alusrcE,
    output logic [1:0]     regdstE,
    output logic [ACW-1:0] alucontrolE,
    output logic           regwriteE,
    output logic           regwriteM,
    output logic           regwriteW,
    output logic [1:0]     memtoregE,
    output logic [1:0]     memtoregM,
    output logic [1:0]     memtoregW,
    output logic           memwriteM,
    output logic           loadbyteM,
    output logic           savebyteM,
    output logic           mdu_startE,
    output logic           mdu_opE,
    output logic           mdu_busy,
    output logic           stallF,
    output logic           stallD,
    output logic           moveW,
    output logic           hiloselW
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);

    localparam logic [FNW-1:0] FN_ADD   = FNW'(6'b100000);
    localparam logic [FNW-1:0] FN_SUB   = FNW'(6'b100010);
    localparam logic [FNW-1:0] FN_AND   = FNW'(6'b100100);
    localparam logic [FNW-1:0] FN_OR    = FNW'(6'b100101);
    localparam logic [FNW-1:0] FN_SLT   = FNW'(6'b101010);
    localparam logic [FNW-1:0] FN_JR    = FNW'(6'b001000);
    localparam logic [FNW-1:0] FN_MFHI  = FNW'(6'b010000);
    localparam logic [FNW-1:0] FN_MFLO  = FNW'(6'b010010);
    localparam logic [FNW-1:0] FN_MULT  = FNW'(6'b011000);
    localparam logic [FNW-1:0] FN_DIV   = FNW'(6'b011010);

    localparam logic [ACW-1:0] ALU_AND  = ACW'(4'b0000);
    localparam logic [ACW-1:0] ALU_OR   = ACW'(4'b0001);
    localparam logic [ACW-1:0] ALU_ADD  = ACW'(4'b0010);
    localparam logic [ACW-1:0] ALU_SUB  = ACW'(4'b0110);
    localparam logic [ACW-1:0] ALU_SLT  = ACW'(4'b0111);

    localparam int CNTW = 4;
    localparam logic [CNTW-1:0] LAT_LOAD = CNTW'(MDU_LAT);

    // Control word carried from D into E.
    typedef struct packed {
        logic           regwrite;
        logic [1:0]     memtoreg;
        logic           memwrite;
        logic           loadbyte;
        logic           savebyte;
        logic           alusrc;
        logic [1:0]     regdst;
        logic [ACW-1:0] alucontrol;
        logic           mdu;
        logic           mduop;
        logic           move;
        logic           hilosel;
    } ctrlE_t;

    // Subset still needed in M.
    typedef struct packed {
        logic       regwrite;
        logic [1:0] memtoreg;
        logic       memwrite;
        logic       loadbyte;
        logic       savebyte;
        logic       move;
        logic       hilosel;
    } ctrlM_t;

    // Subset still needed in W.
    typedef struct packed {
        logic       regwrite;
        logic [1:0] memtoreg;
        logic       move;
        logic       hilosel;
    } ctrlW_t;

    ctrlE_t         ctrlD;
    ctrlE_t         ctrlE_d, ctrlE_q;
    ctrlM_t         ctrlM_d, ctrlM_q;
    ctrlW_t         ctrlW_d, ctrlW_q;
    logic [CNTW-1:0] busyCnt_d, busyCnt_q;
    logic           mduUseD;

    // Main decoder. Anything not listed falls through to the all-zero NOP
    // word. jr only exists under the R-type opcode, so a 001000 funct paired
    // with any other opcode does not set jumpR.
    always_comb begin
        ctrlD      = '0;
        branchD    = 1'b0;
        branchNOTD = 1'b0;
        jumpD      = 1'b0;
        jumpR      = 1'b0;
        case (opD)
            OP_RTYPE: begin
                case (functD)
                    FN_ADD: begin
                        ctrlD.regdst     = 2'b01;
                        ctrlD.regwrite   = 1'b1;
                        ctrlD.alucontrol = ALU_ADD;
                    end
                    FN_SUB: begin
                        ctrlD.regdst     = 2'b01;
                        ctrlD.regwrite   = 1'b1;
                        ctrlD.alucontrol = ALU_SUB;
                    end
                    FN_AND: begin
                        ctrlD.regdst     = 2'b01;
                        ctrlD.regwrite   = 1'b1;
                        ctrlD.alucontrol = ALU_AND;
                    end
                    FN_OR: begin
                        ctrlD.regdst     = 2'b01;
                        ctrlD.regwrite   = 1'b1;
                        ctrlD.alucontrol = ALU_OR;
                    end
                    FN_SLT: begin
                        ctrlD.regdst     = 2'b01;
                        ctrlD.regwrite   = 1'b1;
                        ctrlD.alucontrol = ALU_SLT;
                    end
                    FN_JR: begin
                        jumpR = 1'b1;
                    end
                    FN_MFHI: begin
                        ctrlD.regdst   = 2'b01;
                        ctrlD.regwrite = 1'b1;
                        ctrlD.move     = 1'b1;
                        ctrlD.hilosel  = 1'b1;
                    end
                    FN_MFLO: begin
                        ctrlD.regdst   = 2'b01;
                        ctrlD.regwrite = 1'b1;
                        ctrlD.move     = 1'b1;
                    end
                    FN_MULT: begin
                        ctrlD.mdu = 1'b1;
                    end
                    FN_DIV: begin
                        ctrlD.mdu   = 1'b1;
                        ctrlD.mduop = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                ctrlD.alusrc     = 1'b1;
                ctrlD.memtoreg   = 2'b01;
                ctrlD.regwrite   = 1'b1;
                ctrlD.alucontrol = ALU_ADD;
            end
            OP_LB: begin
                ctrlD.alusrc     = 1'b1;
                ctrlD.memtoreg   = 2'b01;
                ctrlD.regwrite   = 1'b1;
                ctrlD.alucontrol = ALU_ADD;
                ctrlD.loadbyte   = 1'b1;
            end
            OP_SW: begin
                ctrlD.alusrc     = 1'b1;
                ctrlD.memwrite   = 1'b1;
                ctrlD.alucontrol = ALU_ADD;
            end
            OP_SB: begin
                ctrlD.alusrc     = 1'b1;
                ctrlD.memwrite   = 1'b1;
                ctrlD.alucontrol = ALU_ADD;
                ctrlD.savebyte   = 1'b1;
            end
            OP_ADDI: begin
                ctrlD.alusrc     = 1'b1;
                ctrlD.regwrite   = 1'b1;
                ctrlD.alucontrol = ALU_ADD;
            end
            OP_BEQ: begin
                branchD          = 1'b1;
                ctrlD.alucontrol = ALU_SUB;
            end
            OP_BNE: begin
                branchNOTD       = 1'b1;
                ctrlD.alucontrol = ALU_SUB;
            end
            OP_J: begin
                jumpD = 1'b1;
            end
            OP_JAL: begin
                jumpD          = 1'b1;
                ctrlD.regdst   = 2'b10;
                ctrlD.memtoreg = 2'b10;
                ctrlD.regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcsrcD = (branchD & equalD) | (branchNOTD & ~equalD);

    // The start pulse in E counts as busy too: the counter only loads on the
    // following edge, so without it a back-to-back MDU user would slip through.
    assign mduUseD    = ctrlD.mdu | ctrlD.move;
    assign mdu_startE = ctrlE_q.mdu;
    assign mdu_busy   = (busyCnt_q != '0);
    assign stallD     = mduUseD & (mdu_busy | mdu_startE);
    assign stallF     = stallD;

    // Next-state for the pipeline registers. A stalled D instruction must not
    // also enter E, so stall and flush both inject a bubble, which also keeps
    // a flushed mult/div from starting the MDU.
    always_comb begin
        ctrlE_d = (flushE | stallD) ? '0 : ctrlD;
        ctrlM_d = '{regwrite: ctrlE_q.regwrite, memtoreg: ctrlE_q.memtoreg,
                    memwrite: ctrlE_q.memwrite, loadbyte: ctrlE_q.loadbyte,
                    savebyte: ctrlE_q.savebyte, move: ctrlE_q.move,
                    hilosel: ctrlE_q.hilosel};
        ctrlW_d = '{regwrite: ctrlM_q.regwrite, memtoreg: ctrlM_q.memtoreg,
                    move: ctrlM_q.move, hilosel: ctrlM_q.hilosel};
    end

    // Busy counter: reload on every start, otherwise count down to zero.
    always_comb begin
        busyCnt_d = busyCnt_q;
        if (ctrlE_q.mdu) begin
            busyCnt_d = LAT_LOAD;
        end else if (busyCnt_q != '0) begin
            busyCnt_d = busyCnt_q - 1'b1;
        end
    end

    // State registers. Reset abandons any MDU operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlE_q   <= '0;
            ctrlM_q   <= '0;
            ctrlW_q   <= '0;
            busyCnt_q <= '0;
        end else begin
            ctrlE_q   <= ctrlE_d;
            ctrlM_q   <= ctrlM_d;
            ctrlW_q   <= ctrlW_d;
            busyCnt_q <= busyCnt_d;
        end
    end

    assign alusrcE     = ctrlE_q.alusrc;
    assign regdstE     = ctrlE_q.regdst;
    assign alucontrolE = ctrlE_q.alucontrol;
    assign regwriteE   = ctrlE_q.regwrite;
    assign memtoregE   = ctrlE_q.memtoreg;
    assign mdu_opE     = ctrlE_q.mduop;

    assign regwriteM   = ctrlM_q.regwrite;
    assign memtoregM   = ctrlM_q.memtoreg;
    assign memwriteM   = ctrlM_q.memwrite;
    assign loadbyteM   = ctrlM_q.loadbyte;
    assign savebyteM   = ctrlM_q.savebyte;

    assign regwriteW   = ctrlW_q.regwrite;
    assign memtoregW   = ctrlW_q.memtoreg;
    assign moveW       = ctrlW_q.move;
    assign hiloselW    = ctrlW_q.hilosel;

endmodule
